// File: rtl/ula8_pipe.sv
// Two-stage pipelined 8-bit ULA: stage 1 captures operands via valid/ready,
// stage 2 holds the computed result, flags and accumulator until consumed.
module ula8_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    input  logic             use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V,
    output logic [WIDTH-1:0] acc
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_PASA = 3'b110;
    localparam logic [2:0] OP_PASB = 3'b111;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_op_q, s1_op_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             accept;
    logic             move;
    logic [WIDTH-1:0] alu_f;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH:0]   sum;

    // Stage 1 may take a new op whenever its current content can leave this edge.
    assign move     = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        sum   = '0;
        alu_f = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (s1_op_q)
            OP_AND:  alu_f = s1_a_q & s1_b_q;
            OP_OR:   alu_f = s1_a_q | s1_b_q;
            OP_XOR:  alu_f = s1_a_q ^ s1_b_q;
            OP_NOT:  alu_f = ~s1_a_q;
            OP_ADD: begin
                sum   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
                alu_f = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                        (alu_f[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_SUB: begin
                sum   = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + (WIDTH+1)'(1);
                alu_f = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                        (alu_f[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_PASA: alu_f = s1_a_q;
            OP_PASB: alu_f = s1_b_q;
            default: alu_f = '0;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = use_acc ? acc_q : A;
            s1_b_d     = B;
            s1_op_d    = op;
        end else if (move) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        f_d         = f_q;
        z_d         = z_q;
        n_d         = n_q;
        c_d         = c_q;
        v_d         = v_q;
        acc_d       = acc_q;
        if (move) begin
            out_valid_d = 1'b1;
            f_d         = alu_f;
            z_d         = (alu_f == '0);
            n_d         = alu_f[WIDTH-1];
            c_d         = alu_c;
            v_d         = alu_v;
            acc_d       = alu_f;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            out_valid_q <= 1'b0;
            f_q         <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            acc_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            f_q         <= f_d;
            z_q         <= z_d;
            n_q         <= n_d;
            c_q         <= c_d;
            v_q         <= v_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign F         = f_q;
    assign Z         = z_q;
    assign N         = n_q;
    assign C         = c_q;
    assign V         = v_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_ula8_pipe.sv
// Bench for ula8_pipe: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_ula8_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] op;
    logic       use_acc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] F;
    logic       Z, N, C, V;
    logic [7:0] acc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ula8_pipe #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op), .use_acc(use_acc), .out_valid(out_valid),
        .out_ready(out_ready), .F(F), .Z(Z), .N(N), .C(C), .V(V), .acc(acc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: ops sit in an ordered queue; the head is "in stage 2" once it
    // has been promoted, and the result is computed from plain arithmetic.
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } op_t;

    op_t        q[$];
    bit         head_s2;
    logic [7:0] m_acc, m_f;
    bit         m_z, m_n, m_c, m_v;

    function automatic logic [11:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] o);
        int ua, ub, sa, sb, r;
        bit c, v;
        logic [7:0] f;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        c = 0;
        v = 0;
        case (o)
            3'd0: r = ua & ub;
            3'd1: r = ua | ub;
            3'd2: r = ua ^ ub;
            3'd3: r = 255 - ua;
            3'd4: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            3'd5: begin r = ua - ub; c = (ua >= ub); v = (sa - sb > 127) || (sa - sb < -128); end
            3'd6: r = ua;
            default: r = ub;
        endcase
        f = r[7:0];
        return {v, c, f[7], (f == 8'h00), f};
    endfunction

    function automatic bit m_in_ready();
        bit s1_occ, s2_occ;
        s2_occ = (q.size() >= 1) && head_s2;
        s1_occ = (q.size() == 2) || (q.size() == 1 && !head_s2);
        return !s1_occ || !s2_occ || out_ready;
    endfunction

    always @(posedge clk or posedge reset) begin : model
        op_t        nxt;
        bit         take;
        logic [11:0] r;
        if (reset) begin
            q.delete();
            head_s2 = 0;
            m_acc = 8'h00; m_f = 8'h00;
            m_z = 0; m_n = 0; m_c = 0; m_v = 0;
        end else begin
            take = in_valid && m_in_ready();
            nxt.a = use_acc ? m_acc : A;
            nxt.b = B;
            nxt.op = op;
            if (head_s2 && out_ready) begin
                void'(q.pop_front());
                head_s2 = 0;
            end
            if (q.size() > 0 && !head_s2) begin
                r = ref_alu(q[0].a, q[0].b, q[0].op);
                m_f = r[7:0];
                m_z = r[8]; m_n = r[9]; m_c = r[10]; m_v = r[11];
                m_acc = m_f;
                head_s2 = 1;
            end
            if (take) q.push_back(nxt);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("in_ready", 32'(in_ready), 32'(m_in_ready()));
            chk("out_valid", 32'(out_valid), 32'(head_s2));
            chk("acc", 32'(acc), 32'(m_acc));
            if (head_s2) begin
                chk("F", 32'(F), 32'(m_f));
                chk("flags", {28'd0, Z, N, C, V}, {28'd0, m_z, m_n, m_c, m_v});
            end
        end
    end

    // Present an op (caller is just after a rising edge) and hold it until accepted.
    task automatic send(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic ua);
        bit ok;
        in_valid = 1'b1; op = o; A = a; B = b; use_acc = ua;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL send_timeout actual=no_accept required=accept at %0t", $time);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [7:0] f, input logic [3:0] znc_v);
        bit ok;
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1;
        end
        chk({name, "_valid"}, 32'(ok), 32'd1);
        chk({name, "_F"}, 32'(F), 32'(f));
        chk({name, "_ZNCV"}, {28'd0, Z, N, C, V}, {28'd0, znc_v});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; A = 8'h00; B = 8'h00; op = 3'd0; use_acc = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_outs", {F, acc, 4'd0, Z, N, C, V, 7'd0, out_valid}, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // XOR with exact latency
        send(3'b010, 8'hA5, 8'h0F, 1'b0);
        @(negedge clk);
        chk("xor_lat_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("xor_lat_valid", 32'(out_valid), 32'd1);
        chk("xor_F", 32'(F), 32'hAA);
        chk("xor_ZNCV", {28'd0, Z, N, C, V}, 32'b0100);
        @(posedge clk);
        #1;

        send(3'b100, 8'h7F, 8'h01, 1'b0);
        expect_out("add_ovf", 8'h80, 4'b0101);
        send(3'b100, 8'hFF, 8'h01, 1'b0);
        expect_out("add_carry", 8'h00, 4'b1010);
        send(3'b101, 8'h05, 8'h07, 1'b0);
        expect_out("sub_borrow", 8'hFE, 4'b0100);
        send(3'b101, 8'h07, 8'h05, 1'b0);
        expect_out("sub_noborrow", 8'h02, 4'b0010);
        send(3'b011, 8'h0F, 8'h00, 1'b0);
        expect_out("not", 8'hF0, 4'b0100);

        // Backpressure: two ops fill the pipe, the third must wait
        out_ready = 1'b0;
        send(3'b111, 8'h00, 8'h11, 1'b0);
        send(3'b111, 8'h00, 8'h22, 1'b0);
        in_valid = 1'b1; op = 3'b111; A = 8'h00; B = 8'h33; use_acc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_F", {23'd0, out_valid, F}, {23'd0, 1'b1, 8'h11});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_ready", 32'(in_ready), 32'd1);
        chk("bp_r1", {23'd0, out_valid, F}, {23'd0, 1'b1, 8'h11});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_r2", {23'd0, out_valid, F}, {23'd0, 1'b1, 8'h22});
        @(negedge clk);
        chk("bp_r3", {23'd0, out_valid, F}, {23'd0, 1'b1, 8'h33});
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Accumulator chain with idle gaps
        send(3'b100, 8'h10, 8'h20, 1'b0);
        expect_out("chain_add", 8'h30, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        chk("chain_acc", 32'(acc), 32'h30);
        send(3'b100, 8'hEE, 8'h05, 1'b1);
        expect_out("chain_acc_add", 8'h35, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        send(3'b010, 8'h00, 8'hFF, 1'b1);
        expect_out("chain_acc_xor", 8'hCA, 4'b0100);

        // Reset with both stages full
        out_ready = 1'b0;
        send(3'b111, 8'h00, 8'h44, 1'b0);
        send(3'b111, 8'h00, 8'h55, 1'b0);
        @(negedge clk);
        chk("pre_rst_full", {30'd0, out_valid, in_ready}, 32'b10);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_acc", 32'(acc), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_F", 32'(F), 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", 32'(out_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
